load_store_unit: RTL and testbench
==================================

# load_store_unit

MEM-stage load/store unit between the pipeline's execute/memory register and the data memory port. It accepts one load or store per request, decodes RV32I width and signedness from funct3, and builds the byte-lane `mem_req_t` (address, byte enables, lane-aligned write data). For loads it holds the pipeline stalled until `mem_resp_t.rvalid`, then extracts, sign- or zero-extends and registers the result for writeback. Misaligned accesses and illegal widths are flagged as exceptions and never reach memory.

## Interface
- No parameters. Width is fixed at 32-bit data and 32-bit address; the memory word index is taken by the memory itself.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  a memory operation is presented this cycle.
- `op_store`  in  1  1 = store, 0 = load; qualified by `op_valid`.
- `op_funct3`  in  3  RV32I width/sign code.
- `op_addr`  in  32  effective byte address.
- `op_wdata`  in  32  store source register, value in low bits.
- `op_rd`  in  5  load destination register.
- `flush`  in  1  squash the current/pending operation's writeback.
- `req`  out  mem_req_t  {valid, we, addr[31:0], be[3:0], wdata[31:0]} to data memory.
- `resp`  in  mem_resp_t  {ready, rvalid, rdata[31:0]} from data memory.
- `stall`  out  1  hold the upstream pipeline this cycle.
- `ld_valid`  out  1  one-cycle pulse, load result valid.
- `ld_data`  out  32  extended load result.
- `ld_rd`  out  5  destination of `ld_data`.
- `exc_valid`  out  1  one-cycle exception pulse.
- `exc_cause`  out  2  01 load misaligned, 10 store misaligned, 11 illegal funct3.
- `exc_addr`  out  32  faulting `op_addr`.

## Operation
- Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other code is illegal (cause 11).
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0. Misaligned and illegal operations drive `req.valid`=0 and pulse `exc_*` next cycle. `stall`=0. Illegal is checked before misaligned.
- Byte enables: byte `be`=1<<addr[1:0]; half `be`=4'b0011<<addr[1:0]; word 4'b1111. `req.wdata` is the store data replicated across lanes: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- `req.addr`=`op_addr` unmodified. `req.we`=`op_store`.
- FSM `IDLE`, `WAIT`:
  - In `IDLE`, with `op_valid`, a legal op and `resp.ready`=1, `req.valid`=1 combinationally.
  - A store completes in that cycle and stays in `IDLE`.
  - A load latches `op_rd`, funct3 and addr[1:0], then goes to `WAIT`.
  - In `WAIT`, `req.valid`=0. On `resp.rvalid`, the unit shifts `rdata` right by 8·addr[1:0], extends per funct3, registers `ld_data`/`ld_rd`, and pulses `ld_valid` unless squashed. It then returns to `IDLE`.
- `flush` asserted in `IDLE` suppresses issuing the presented op. `flush` asserted in `WAIT`, or on the `rvalid` cycle, sets a squash flag. The unit still waits for `rvalid` and drops the result: no `ld_valid`.
- `resp.ready`=0 in `IDLE` with a legal op: no request is issued, `stall`=1, and the unit retries every cycle.
- `resp.rvalid` arriving in `IDLE` is ignored.

## Timing
- Reset (async assert, sync release): state `IDLE`, squash flag 0, `ld_valid`=0, `ld_data`=0, `ld_rd`=0, `exc_valid`=0, `exc_cause`=0, `exc_addr`=0.
- `req` and `stall` are combinational. While `rst`=0: `req.valid`=0 and `stall`=0.
- `stall` = (`IDLE` & `op_valid` & legal & !`flush` & (!`resp.ready` | load)) | (`WAIT` & !`resp.rvalid`).
- Load with a 1-cycle memory:
  - cycle 0: request issued, `stall`=1.
  - cycle 1: `rvalid`, `stall`=0.
  - cycle 2: `ld_valid`=1.
  - Latency from request to result is 2 cycles; a back-to-back load may issue in cycle 2.
- Store: 0 stall cycles. A new op is accepted every cycle.
- Exceptions: `exc_valid` is high the cycle after the op is presented, for exactly 1 cycle.
- Reset asserted in `WAIT`: the unit returns to `IDLE`. A later `rvalid` is ignored.

## Test plan
- SW addr 0x100, data 0xDEADBEEF -> same cycle `req`={valid 1, we 1, be 1111, wdata 0xDEADBEEF}, `stall`=0. A following LW 0x100 -> `ld_data`=0xDEADBEEF two cycles after issue.
- SB addr 0x103, data 0x80, then LB 0x103 -> `be`=1000, `wdata`=0x80808080. The load returns `ld_data`=0xFFFFFF80; LBU of the same address returns 0x00000080.
- SH addr 0x102, data 0x8001, then LH 0x102 -> `be`=1100, `ld_data`=0xFFFF8001; LHU returns 0x00008001.
- LW addr 0x101 -> no `req.valid`, next cycle `exc_valid`=1, `exc_cause`=01, `exc_addr`=0x101. funct3=011 -> `exc_cause`=11.
- LW issued, `flush` asserted in `WAIT`, `rvalid` one cycle later -> `ld_valid` stays 0 and the FSM returns to `IDLE`. Separately, `resp.ready`=0 for 3 cycles -> `stall`=1 for 3 cycles, and the request issues on the 4th cycle.
- Reset pulsed low while in `WAIT` -> all outputs 0, state `IDLE`, and the stray `rvalid` after reset produces no `ld_valid`.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage RV32I load/store with byte lanes, load extension and exceptions.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [4:0]  op_rd,
  input  logic        flush,
  output logic [69:0] req,
  input  logic [33:0] resp,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [4:0]  ld_rd,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q, state_d;
  logic        squash_q, squash_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        ld_valid_q, ld_valid_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_addr_q, exc_addr_d;
  logic        resp_ready, resp_rvalid;
  logic [31:0] rdata;
  logic        illegal, misal, fault, go;
  logic [3:0]  be;
  logic [31:0] wdata, shifted, ext;
  assign {resp_ready, resp_rvalid, rdata} = resp;
  always_comb begin
    illegal = op_store ? (op_funct3[2] | (&op_funct3[1:0])) : ((&op_funct3[1:0]) | (op_funct3[2] & op_funct3[1]));
    misal   = (op_funct3[1:0] == 2'b01 & op_addr[0]) | (op_funct3[1:0] == 2'b10 & |op_addr[1:0]);
    fault   = illegal | misal;
    go      = rst & (state_q == IDLE) & op_valid & !fault & !flush;
    be      = op_funct3[1] ? 4'b1111 : op_funct3[0] ? 4'b0011 << op_addr[1:0] : 4'b0001 << op_addr[1:0];
    wdata   = op_funct3[1] ? op_wdata : op_funct3[0] ? {2{op_wdata[15:0]}} : {4{op_wdata[7:0]}};
    req     = {go & resp_ready, op_store, op_addr, be, wdata};
    stall   = rst & ((go & (!resp_ready | !op_store)) | (state_q == WAIT & !resp_rvalid));
    shifted = rdata >> {off_q, 3'b000};
    ext     = f3_q[1] ? shifted :
              f3_q[0] ? {{16{shifted[15] & !f3_q[2]}}, shifted[15:0]} :
                        {{24{shifted[7] & !f3_q[2]}}, shifted[7:0]};
    state_d     = state_q;
    squash_d    = squash_q;
    rd_d        = rd_q;
    f3_d        = f3_q;
    off_d       = off_q;
    ld_valid_d  = 1'b0;
    ld_data_d   = ld_data_q;
    ld_rd_d     = ld_rd_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;
    if (state_q == IDLE) begin
      if (go & resp_ready & !op_store) begin
        state_d  = WAIT;
        squash_d = 1'b0;
        rd_d     = op_rd;
        f3_d     = op_funct3;
        off_d    = op_addr[1:0];
      end
      if (op_valid & fault & !flush) begin
        exc_valid_d = 1'b1;
        exc_cause_d = illegal ? 2'b11 : op_store ? 2'b10 : 2'b01;
        exc_addr_d  = op_addr;
      end
    end else begin
      squash_d = squash_q | flush;
      if (resp_rvalid) begin
        state_d    = IDLE;
        squash_d   = 1'b0;
        ld_valid_d = !(squash_q | flush);
        ld_data_d  = ext;
        ld_rd_d    = rd_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      squash_q    <= 1'b0;
      rd_q        <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
      ld_rd_q     <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      squash_q    <= squash_d;
      rd_q        <= rd_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
      ld_rd_q     <= ld_rd_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign ld_rd     = ld_rd_q;
  assign exc_valid = exc_valid_q;
  assign exc_cause = exc_cause_q;
  assign exc_addr  = exc_addr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a latency-programmable data memory model.
module tb_load_store_unit;
  logic        clk = 0, rst = 0;
  logic        op_valid = 0, op_store = 0, flush = 0;
  logic [2:0]  op_funct3 = 0;
  logic [31:0] op_addr = 0, op_wdata = 0;
  logic [4:0]  op_rd = 0;
  logic [69:0] req;
  logic [33:0] resp;
  logic        stall, ld_valid, exc_valid;
  logic [31:0] ld_data, exc_addr;
  logic [4:0]  ld_rd;
  logic [1:0]  exc_cause;
  logic        ready = 1;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] pend;
  logic [31:0] mem [0:255];
  int          checks = 0, failures = 0;
  logic [36:0] ld_q[$];
  logic [33:0] exc_q[$];
  logic [36:0] ld_exp;
  logic [33:0] exc_exp;
  always #5 clk = ~clk;
  assign resp = {ready, cnt == 1, pend};
  load_store_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_store(op_store), .op_funct3(op_funct3),
    .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd), .flush(flush), .req(req),
    .resp(resp), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );
  always @(posedge clk) begin
    if (cnt > 0) cnt <= cnt - 1;
    if (req[69] && !req[68]) begin
      cnt  <= lat;
      pend <= mem[req[45:38]];
    end
    if (req[69] && req[68])
      for (int b = 0; b < 4; b++)
        if (req[32+b]) mem[req[45:38]][8*b +: 8] <= req[8*b +: 8];
  end
  always @(negedge clk) if (rst) begin
    if (ld_valid) begin
      checks++;
      if (ld_q.size() == 0) begin
        failures++;
        $display("FAIL ld_unexpected got rd=%0d data=%h want no load", ld_rd, ld_data);
      end else begin
        ld_exp = ld_q.pop_front();
        if ({ld_rd, ld_data} !== ld_exp) begin
          failures++;
          $display("FAIL ld_result got rd=%0d data=%h want rd=%0d data=%h", ld_rd, ld_data, ld_exp[36:32], ld_exp[31:0]);
        end
      end
    end
    if (exc_valid) begin
      checks++;
      if (exc_q.size() == 0) begin
        failures++;
        $display("FAIL exc_unexpected got cause=%b addr=%h want none", exc_cause, exc_addr);
      end else begin
        exc_exp = exc_q.pop_front();
        if ({exc_cause, exc_addr} !== exc_exp) begin
          failures++;
          $display("FAIL exc_result got cause=%b addr=%h want cause=%b addr=%h", exc_cause, exc_addr, exc_exp[33:32], exc_exp[31:0]);
        end
      end
    end
  end
  task automatic drive(input logic v, input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    op_valid = v; op_store = s; op_funct3 = f; op_addr = a; op_wdata = d; op_rd = r;
  endtask
  task automatic idle();
    drive(0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
  endtask
  task automatic do_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, input logic [3:0] ebe, input logic [31:0] ew, input string name);
    @(negedge clk);
    drive(1, 1, f, a, d, 5'd0);
    #1;
    checks++;
    if ({req, stall} !== {1'b1, 1'b1, a, ebe, ew, 1'b0}) begin
      failures++;
      $display("FAIL %s got req=%h stall=%b want req=%h stall=0", name, req, stall, {1'b1, 1'b1, a, ebe, ew});
    end
  endtask
  task automatic do_load(input logic [2:0] f, input logic [31:0] a, input logic [4:0] rd, input logic [31:0] ed, input logic [3:0] ebe, input string name);
    int n = 0;
    @(negedge clk);
    ld_q.push_back({rd, ed});
    drive(1, 0, f, a, 32'd0, rd);
    #1;
    checks++;
    if ({req[69:32], stall} !== {1'b1, 1'b0, a, ebe, 1'b1}) begin
      failures++;
      $display("FAIL %s_issue got req=%h stall=%b want v=1 we=0 addr=%h be=%b stall=1", name, req[69:32], stall, a, ebe);
    end
    @(negedge clk);
    idle();
    while (!ld_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ld_valid || n != 1) begin
      failures++;
      $display("FAIL %s_latency got %0d cycles want 2", name, n + 1);
    end
  endtask
  task automatic exc_case(input logic s, input logic [2:0] f, input logic [31:0] a, input logic [1:0] cause, input string name);
    @(negedge clk);
    exc_q.push_back({cause, a});
    drive(1, s, f, a, 32'h1234_5678, 5'd4);
    #1;
    checks++;
    if (req[69] !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL %s_noreq got valid=%b stall=%b want 0 0", name, req[69], stall);
    end
    @(negedge clk);
    idle();
    checks++;
    if (exc_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_pulse got exc_valid=%b want 1", name, exc_valid);
    end
    @(negedge clk);
    checks++;
    if (exc_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_width got exc_valid=%b want 0", name, exc_valid);
    end
  endtask
  task automatic test_reset();
    drive(1, 1, 3'b010, 32'h100, 32'h1, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req[69], stall, ld_valid, ld_data, ld_rd, exc_valid, exc_cause, exc_addr} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b stall=%b ldv=%b ld=%h rd=%0d excv=%b cause=%b ea=%h want all 0",
               req[69], stall, ld_valid, ld_data, ld_rd, exc_valid, exc_cause, exc_addr);
    end
    @(negedge clk);
    idle();
    rst = 1;
  endtask
  task automatic test_word();
    do_store(3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, "sw");
    do_load(3'b010, 32'h100, 5'd5, 32'hDEADBEEF, 4'b1111, "lw");
  endtask
  task automatic test_byte();
    do_store(3'b000, 32'h103, 32'h0000_0080, 4'b1000, 32'h80808080, "sb");
    do_load(3'b000, 32'h103, 5'd6, 32'hFFFFFF80, 4'b1000, "lb");
    do_load(3'b100, 32'h103, 5'd7, 32'h00000080, 4'b1000, "lbu");
    do_load(3'b100, 32'h101, 5'd8, 32'h000000BE, 4'b0010, "lbu1");
    do_load(3'b010, 32'h100, 5'd9, 32'h80ADBEEF, 4'b1111, "lw_b");
  endtask
  task automatic test_half();
    do_store(3'b001, 32'h102, 32'h0000_8001, 4'b1100, 32'h80018001, "sh");
    do_load(3'b001, 32'h102, 5'd10, 32'hFFFF8001, 4'b1100, "lh");
    do_load(3'b101, 32'h102, 5'd11, 32'h00008001, 4'b1100, "lhu");
    do_load(3'b001, 32'h100, 5'd12, 32'hFFFFBEEF, 4'b0011, "lh0");
    do_load(3'b101, 32'h100, 5'd13, 32'h0000BEEF, 4'b0011, "lhu0");
  endtask
  task automatic test_exc();
    exc_case(0, 3'b010, 32'h101, 2'b01, "lw_misal");
    exc_case(0, 3'b001, 32'h103, 2'b01, "lh_misal");
    exc_case(1, 3'b010, 32'h102, 2'b10, "sw_misal");
    exc_case(0, 3'b011, 32'h100, 2'b11, "ld_f3_011");
    exc_case(0, 3'b011, 32'h101, 2'b11, "illegal_first");
    exc_case(1, 3'b100, 32'h100, 2'b11, "st_f3_100");
  endtask
  task automatic test_flush();
    lat = 2;
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h100, 32'd0, 5'd14);
    #1;
    checks++;
    if (req[69] !== 1'b1) begin
      failures++;
      $display("FAIL flush_issue got valid=%b want 1", req[69]);
    end
    @(negedge clk);
    idle();
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL flush_wait_stall got %b want 1", stall);
    end
    @(negedge clk);
    flush = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_rvalid_stall got %b want 0", stall);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ld_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_dropped got ld_valid=%b want 0", ld_valid);
      end
    end
    lat = 1;
    do_store(3'b010, 32'h104, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, "flush_idle_after");
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h100, 32'd0, 5'd15);
    flush = 1;
    #1;
    checks++;
    if (req[69] !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_suppress got valid=%b stall=%b want 0 0", req[69], stall);
    end
    @(negedge clk);
    flush = 0;
    drive(1, 0, 3'b010, 32'h100, 32'd0, 5'd16);
    @(negedge clk);
    idle();
    flush = 1;
    repeat (3) begin
      @(negedge clk);
      flush = 0;
      checks++;
      if (ld_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_on_rvalid got ld_valid=%b want 0", ld_valid);
      end
    end
  endtask
  task automatic test_ready();
    int n = 0;
    @(negedge clk);
    ready = 0;
    ld_q.push_back({5'd17, 32'h8001BEEF});
    drive(1, 0, 3'b010, 32'h100, 32'd0, 5'd17);
    repeat (3) begin
      #1;
      checks++;
      if (stall !== 1'b1 || req[69] !== 1'b0) begin
        failures++;
        $display("FAIL ready_hold got stall=%b valid=%b want 1 0", stall, req[69]);
      end
      @(negedge clk);
    end
    ready = 1;
    #1;
    checks++;
    if (stall !== 1'b1 || req[69] !== 1'b1) begin
      failures++;
      $display("FAIL ready_issue got stall=%b valid=%b want 1 1", stall, req[69]);
    end
    @(negedge clk);
    idle();
    while (!ld_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ld_valid) begin
      failures++;
      $display("FAIL ready_timeout got no ld_valid want ld_valid");
    end
  endtask
  task automatic test_back_to_back();
    do_store(3'b000, 32'h110, 32'h0000_0011, 4'b0001, 32'h11111111, "b2b_sb0");
    do_store(3'b000, 32'h111, 32'h0000_0022, 4'b0010, 32'h22222222, "b2b_sb1");
    do_store(3'b001, 32'h112, 32'h0000_A5C3, 4'b1100, 32'hA5C3A5C3, "b2b_sh");
    @(negedge clk);
    ld_q.push_back({5'd1, 32'hA5C32211});
    drive(1, 0, 3'b010, 32'h110, 32'd0, 5'd1);
    @(negedge clk);
    idle();
    @(negedge clk);
    ld_q.push_back({5'd2, 32'h000000A5});
    drive(1, 0, 3'b100, 32'h113, 32'd0, 5'd2);
    #1;
    checks++;
    if (req[69] !== 1'b1 || ld_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_issue got valid=%b ld_valid=%b want 1 1", req[69], ld_valid);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++;
    if (ld_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got ld_valid=%b want 1", ld_valid);
    end
  endtask
  task automatic test_reset_wait();
    lat = 3;
    @(negedge clk);
    drive(1, 0, 3'b010, 32'h100, 32'd0, 5'd20);
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL rstw_wait got stall=%b want 1", stall);
    end
    rst = 0;
    drive(1, 1, 3'b010, 32'h100, 32'h5, 5'd0);
    #1;
    checks++;
    if ({req[69], stall, ld_valid, ld_data, ld_rd, exc_valid, exc_cause, exc_addr} !== '0) begin
      failures++;
      $display("FAIL rstw_outputs got valid=%b stall=%b ldv=%b ld=%h rd=%0d excv=%b cause=%b ea=%h want all 0",
               req[69], stall, ld_valid, ld_data, ld_rd, exc_valid, exc_cause, exc_addr);
    end
    @(negedge clk);
    idle();
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ld_valid !== 1'b0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL rstw_stray got ld_valid=%b stall=%b want 0 0", ld_valid, stall);
      end
    end
    lat = 1;
    do_store(3'b010, 32'h108, 32'hCAFE_0001, 4'b1111, 32'hCAFE_0001, "rstw_idle");
    @(negedge clk);
    idle();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_exc();
    test_flush();
    test_ready();
    test_back_to_back();
    test_reset_wait();
    repeat (2) @(negedge clk);
    checks++;
    if (ld_q.size() != 0 || exc_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got ld=%0d exc=%0d pending want 0 0", ld_q.size(), exc_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
